// File: rtl/hid_key_decoder.sv
// Boot-keyboard report scanner: detects new key presses and queues them in a FWFT event FIFO.
// Define HID_ASCII_EN to translate usage codes to ASCII at push time; default pushes raw codes.
//
// state | meaning
// IDLE  | waiting for a report strobe; all-0x01 rollover reports are dropped here
// SCAN  | evaluating one keycode slot per cycle against the previous report
module hid_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        axi_clk,
    input  logic        rst,
    input  logic [63:0] usb_data_i,
    input  logic        usb_data_valid_i,
    output logic [7:0]  key_o,
    output logic [7:0]  mod_o,
    output logic        key_valid_o,
    input  logic        key_ready_i,
    output logic        overflow_o,
    input  logic        ovf_clr_i
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state;
    logic [2:0]    slot;
    logic [63:0]   report;
    logic [47:0]   prev_keys;

    logic [7:0]    code;
    logic          held;
    logic          phantom;
    logic [7:0]    xlat_code;
    logic          xlat_ok;

    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          ovf_set;

    logic [7:0]    mem_key [FIFO_DEPTH];
    logic [7:0]    mem_mod [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_comb begin
        code = 8'h00;
        case (slot)
            3'd0:    code = report[23:16];
            3'd1:    code = report[31:24];
            3'd2:    code = report[39:32];
            3'd3:    code = report[47:40];
            3'd4:    code = report[55:48];
            3'd5:    code = report[63:56];
            default: code = 8'h00;
        endcase
    end

    always_comb begin
        held = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (prev_keys[8*i +: 8] == code) begin
                held = 1'b1;
            end
        end
    end

    assign phantom = (usb_data_i[63:16] == {6{8'h01}});

`ifdef HID_ASCII_EN
    logic shift;
    assign shift = report[1] | report[5];

    always_comb begin
        xlat_ok   = 1'b1;
        xlat_code = 8'h00;
        if (code >= 8'h04 && code <= 8'h1D) begin
            xlat_code = (shift ? 8'h41 : 8'h61) + (code - 8'h04);
        end else if (code >= 8'h1E && code <= 8'h26) begin
            xlat_code = 8'h31 + (code - 8'h1E);
        end else if (code == 8'h27) begin
            xlat_code = 8'h30;
        end else if (code == 8'h28) begin
            xlat_code = 8'h0D;
        end else if (code == 8'h2C) begin
            xlat_code = 8'h20;
        end else begin
            xlat_ok = 1'b0;
        end
    end
`else
    assign xlat_ok   = 1'b1;
    assign xlat_code = code;
`endif

    assign full        = (count == DEPTH_C);
    assign key_valid_o = (count != '0);
    assign pop         = key_valid_o && key_ready_i;
    assign push        = (state == SCAN) && (code != 8'h00) && (code != 8'h01) && !held && xlat_ok;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = push && (!full || pop);
    assign ovf_set     = (push && full && !pop) || (usb_data_valid_i && state == SCAN);

    assign key_o = key_valid_o ? mem_key[rd_ptr] : 8'h00;
    assign mod_o = key_valid_o ? mem_mod[rd_ptr] : 8'h00;

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= 3'd0;
            report    <= 64'h0;
            prev_keys <= 48'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (usb_data_valid_i && !phantom) begin
                        report <= usb_data_i;
                        slot   <= 3'd0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (slot == 3'd5) begin
                        prev_keys <= report[63:16];
                        slot      <= 3'd0;
                        state     <= IDLE;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (push_ok) begin
            mem_key[wr_ptr] <= xlat_code;
            mem_mod[wr_ptr] <= report[7:0];
        end
    end

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hid_key_decoder.sv
// Scoreboard bench for hid_key_decoder: directed scenarios plus randomized reports
// checked against a slot-by-slot press model; honours HID_ASCII_EN.
module tb_hid_key_decoder;

    localparam int DEPTH = 8;
`ifdef HID_ASCII_EN
    localparam logic [7:0] EXP_A = 8'h61;
`else
    localparam logic [7:0] EXP_A = 8'h04;
`endif

    logic        axi_clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] usb_data_i = 64'h0;
    logic        usb_data_valid_i = 1'b0;
    logic [7:0]  key_o;
    logic [7:0]  mod_o;
    logic        key_valid_o;
    logic        key_ready_i = 1'b1;
    logic        overflow_o;
    logic        ovf_clr_i = 1'b0;

    hid_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .axi_clk          (axi_clk),
        .rst              (rst),
        .usb_data_i       (usb_data_i),
        .usb_data_valid_i (usb_data_valid_i),
        .key_o            (key_o),
        .mod_o            (mod_o),
        .key_valid_o      (key_valid_o),
        .key_ready_i      (key_ready_i),
        .overflow_o       (overflow_o),
        .ovf_clr_i        (ovf_clr_i)
    );

    always #5 axi_clk = ~axi_clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  prev_m[6];
    bit          exp_ovf = 1'b0;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] stall_val;
    logic [7:0]  pool[12] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h1D,
                              8'h1E, 8'h27, 8'h28, 8'h2C, 8'h02, 8'h39};

    // Reference translation: returns 1 when the code produces an event.
    function automatic bit xlat(input logic [7:0] c, input logic [7:0] m, output logic [7:0] k);
        k = c;
`ifdef HID_ASCII_EN
        if (c >= 8'h04 && c <= 8'h1D) begin
            k = ((m[1] || m[5]) ? 8'h41 : 8'h61) + c - 8'h04;
            return 1'b1;
        end
        if (c >= 8'h1E && c <= 8'h26) begin
            k = 8'h31 + c - 8'h1E;
            return 1'b1;
        end
        if (c == 8'h27) begin k = 8'h30; return 1'b1; end
        if (c == 8'h28) begin k = 8'h0D; return 1'b1; end
        if (c == 8'h2C) begin k = 8'h20; return 1'b1; end
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_report(input logic [63:0] r);
        logic [7:0] s[6];
        logic [7:0] k;
        bit         all1;
        bit         seen;
        all1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s[i] = r[8*i+16 +: 8];
            if (s[i] != 8'h01) all1 = 1'b0;
        end
        if (all1) return;
        for (int i = 0; i < 6; i++) begin
            seen = 1'b0;
            for (int j = 0; j < 6; j++) if (prev_m[j] == s[i]) seen = 1'b1;
            if (s[i] != 8'h00 && s[i] != 8'h01 && !seen && xlat(s[i], r[7:0], k)) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({k, r[7:0]});
                else exp_ovf = 1'b1;
            end
        end
        for (int i = 0; i < 6; i++) prev_m[i] = s[i];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
        if (rand_ready) key_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) prev_m[i] = 8'h00;
        exp_ovf = 1'b0;
    endtask

    task automatic send(input logic [63:0] r, input bit chk_lat);
        tick();
        usb_data_i = r;
        usb_data_valid_i = 1'b1;
        model_report(r);
        tick();
        usb_data_valid_i = 1'b0;
        if (chk_lat) begin
            @(negedge axi_clk);
            check("lat_cycle1_valid", 16'(key_valid_o), 16'h0);
            @(negedge axi_clk);
            check("lat_cycle2_valid", 16'(key_valid_o), 16'h1);
            check("first_key", 16'(key_o), 16'(EXP_A));
            check("first_mod", 16'(mod_o), 16'h0);
        end
    endtask

    task automatic gap();
        repeat (6) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout actual_left=%0d required_left=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted head is compared to the oldest expected event.
    always @(negedge axi_clk) begin
        if (!rst) begin
            if (key_valid_o && key_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event actual=%h required=none", {key_o, mod_o});
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({key_o, mod_o} !== e) begin
                        bad++;
                        $display("FAIL event actual=%h required=%h", {key_o, mod_o}, e);
                    end
                end
            end
            if (stall_prev && key_valid_o) begin
                total++;
                if ({key_o, mod_o} !== stall_val) begin
                    bad++;
                    $display("FAIL head_hold actual=%h required=%h", {key_o, mod_o}, stall_val);
                end
            end
            stall_prev = key_valid_o && !key_ready_i;
            stall_val  = {key_o, mod_o};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;

        apply_reset();
        @(negedge axi_clk);
        check("rst_valid", 16'(key_valid_o), 16'h0);
        check("rst_key", 16'(key_o), 16'h0);
        check("rst_mod", 16'(mod_o), 16'h0);
        check("rst_ovf", 16'(overflow_o), 16'h0);

        // single press, latency
        send(64'h0000_0000_0004_0000, 1'b1);
        gap();
        drain(50);

        // held key then a shifted new key
        send(64'h0000_0000_0004_0000, 1'b0);
        gap();
        @(negedge axi_clk);
        check("repeat_no_event", 16'(key_valid_o), 16'h0);
        drain(50);
        send(64'h0000_0000_0504_0002, 1'b0);
        gap();
        drain(50);

        // rollover report, then the previous real report again
        send(64'h0101_0101_0101_0000, 1'b0);
        send(64'h0000_0000_0504_0002, 1'b0);
        gap();
        @(negedge axi_clk);
        check("phantom_no_event", 16'(key_valid_o), 16'h0);
        check("phantom_ovf", 16'(overflow_o), 16'(exp_ovf));
        drain(50);

        // strobe arriving mid-scan
        send(64'h0000_0000_0706_0000, 1'b0);
        tick();
        tick();
        usb_data_i = 64'h0000_0000_0908_0000;
        usb_data_valid_i = 1'b1;
        tick();
        usb_data_valid_i = 1'b0;
        exp_ovf = 1'b1;
        gap();
        drain(50);
        @(negedge axi_clk);
        check("busy_strobe_ovf", 16'(overflow_o), 16'(exp_ovf));
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        exp_ovf = 1'b0;
        @(negedge axi_clk);
        check("busy_ovf_clear", 16'(overflow_o), 16'h0);

        // FIFO overflow with a stalled consumer
        apply_reset();
        key_ready_i = 1'b0;
        send(64'h0908_0706_0504_0000, 1'b0);
        gap();
        send(64'h0F0E_0D0C_0B0A_0000, 1'b0);
        gap();
        tick();
        @(negedge axi_clk);
        check("full_valid", 16'(key_valid_o), 16'h1);
        check("full_ovf", 16'(overflow_o), 16'(exp_ovf));
        key_ready_i = 1'b1;
        drain(100);
        tick();
        @(negedge axi_clk);
        check("full_drained", 16'(key_valid_o), 16'h0);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        exp_ovf = 1'b0;
        @(negedge axi_clk);
        check("full_ovf_clear", 16'(overflow_o), 16'h0);

        // reset during slot 3
        apply_reset();
        key_ready_i = 1'b0;
        send(64'h0908_0706_0504_0000, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge axi_clk);
        check("midscan_rst_valid", 16'(key_valid_o), 16'h0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) prev_m[i] = 8'h00;
        exp_ovf = 1'b0;
        @(negedge axi_clk);
        check("midscan_post_valid", 16'(key_valid_o), 16'h0);
        key_ready_i = 1'b1;
        send(64'h0908_0706_0504_0000, 1'b0);
        gap();
        drain(100);

        // randomized reports, random consumer stalls
        apply_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r = 64'h0;
            r[7:0]  = 8'($urandom);
            r[15:8] = 8'($urandom);
            for (int i = 0; i < 6; i++) r[8*i+16 +: 8] = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) r[63:16] = {6{8'h01}};
            send(r, 1'b0);
            gap();
            drain(300);
            @(negedge axi_clk);
            check("rand_ovf", 16'(overflow_o), 16'(exp_ovf));
        end
        rand_ready = 1'b0;
        key_ready_i = 1'b1;
        tick();
        @(negedge axi_clk);
        check("final_empty", 16'(key_valid_o), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
